rv64_multicycle_ctrl: RTL and testbench

Multi-cycle sequencing controller for the RV64I datapath. Holds the instruction register and steps each instruction through FETCH, DECODE, EXEC, MEM and WB. From the instruction it drives the immediate-format select into the immediate generator, plus the ALU operand muxes, PC update, register-file write and memory handshakes. It retires exactly one instruction per pass and keeps a retired-instruction counter.

---
 rtl/rv64_multicycle_ctrl.sv | 99 +++++++++
 tb/tb_rv64_multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv64_multicycle_ctrl.sv
// rv64_multicycle_ctrl: multi-cycle RV64I sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP) with instruction register and retire counter
module rv64_multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [2:0]  immGenType,
  output logic        alu_src_a,
  output logic        alu_src_b,
  input  logic        branch_taken,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        retire,
  output logic [63:0] instret,
  output logic        illegal
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [3:0] {C_LUI, C_AUIPC, C_JAL, C_JALR, C_LOAD, C_STORE, C_OPIMM, C_OP, C_BRANCH, C_ILL} cls_t;
  state_t      state_q, state_d;
  cls_t        cls;
  logic [31:0] inst_q, inst_d;
  logic [63:0] instret_q, instret_d;
  logic        run, in_exec, in_mem, in_wb, br_done, st_done;
  always_comb begin
    cls = C_ILL;
    case (inst_q[6:0])
      7'b0110111: cls = C_LUI;
      7'b0010111: cls = C_AUIPC;
      7'b1101111: cls = C_JAL;
      7'b1100111: cls = C_JALR;
      7'b0000011: cls = C_LOAD;
      7'b0100011: cls = C_STORE;
      7'b0010011, 7'b0011011: cls = C_OPIMM;
      7'b0110011, 7'b0111011: cls = C_OP;
      7'b1100011: cls = C_BRANCH;
      default: cls = C_ILL;
    endcase
  end
  assign immGenType = (cls == C_LUI || cls == C_AUIPC) ? 3'b000 :
                      cls == C_JAL ? 3'b001 :
                      (cls == C_JALR || cls == C_LOAD || cls == C_OPIMM) ? 3'b010 :
                      cls == C_BRANCH ? 3'b011 :
                      cls == C_STORE ? 3'b100 : 3'b111;
  assign run       = !reset;
  assign in_exec   = run && state_q == S_EXEC;
  assign in_mem    = run && state_q == S_MEM;
  assign in_wb     = run && state_q == S_WB;
  assign br_done   = in_exec && cls == C_BRANCH;
  assign st_done   = in_mem && cls == C_STORE && dmem_ready;
  assign imem_req  = run && state_q == S_FETCH;
  assign dmem_req  = in_mem;
  assign dmem_we   = in_mem && cls == C_STORE;
  assign alu_src_a = in_exec && (cls == C_AUIPC || cls == C_JAL);
  assign alu_src_b = in_exec && !(cls == C_OP || cls == C_BRANCH);
  assign retire    = in_wb || br_done || st_done;
  assign pc_we     = retire;
  assign rf_we     = in_wb;
  assign wb_sel    = !in_wb ? 2'b00 : cls == C_LUI ? 2'b11 :
                     (cls == C_JAL || cls == C_JALR) ? 2'b10 : cls == C_LOAD ? 2'b01 : 2'b00;
  assign pc_src    = br_done ? (branch_taken ? 2'b01 : 2'b00) : !in_wb ? 2'b00 :
                     cls == C_JAL ? 2'b01 : cls == C_JALR ? 2'b10 : 2'b00;
  assign illegal   = run && state_q == S_TRAP;
  assign inst      = inst_q;
  assign instret   = instret_q;
  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    instret_d = instret_q + {63'd0, retire};
    case (state_q)
      S_FETCH: begin
        state_d = imem_ready ? S_DECODE : S_FETCH;
        inst_d  = imem_ready ? imem_rdata : inst_q;
      end
      S_DECODE: state_d = cls == C_ILL ? S_TRAP : cls == C_LUI ? S_WB : S_EXEC;
      S_EXEC:   state_d = cls == C_BRANCH ? S_FETCH : (cls == C_LOAD || cls == C_STORE) ? S_MEM : S_WB;
      S_MEM:    state_d = !dmem_ready ? S_MEM : cls == C_STORE ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_TRAP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      inst_q    <= 32'h0000_0013;
      instret_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
    end
  end
endmodule

// File: tb/tb_rv64_multicycle_ctrl.sv
// tb_rv64_multicycle_ctrl: scoreboard bench with a per-instruction reference model for rv64_multicycle_ctrl
module tb_rv64_multicycle_ctrl;
  logic        clk = 0, reset = 1, imem_ready = 0, branch_taken = 0, dmem_ready = 0;
  logic [31:0] imem_rdata = 0;
  logic        imem_req, alu_src_a, alu_src_b, pc_we, rf_we, dmem_req, dmem_we, retire, illegal;
  logic [31:0] inst;
  logic [2:0]  igt;
  logic [1:0]  pc_src, wb_sel;
  logic [63:0] instret;

  rv64_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst(inst), .immGenType(igt), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .branch_taken(branch_taken), .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .wb_sel(wb_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready), .retire(retire),
    .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [2:0]  igt;
    logic        rf, a, b, mreq, mwe;
    logic [1:0]  wb, pc;
    int          cyc, mcyc;
    logic [63:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, errors = 0;
  logic [63:0] n_model = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w, input int iw, input int dw, input logic bt, input logic [63:0] cnt);
    exp_t e;
    e.w = w; e.igt = 3'b111; e.rf = 0; e.a = 0; e.b = 0; e.mreq = 0; e.mwe = 0;
    e.wb = 2'b00; e.pc = 2'b00; e.cyc = 4 + iw; e.mcyc = 0; e.cnt = cnt;
    case (w[6:0])
      7'b0110111: begin e.igt = 3'b000; e.rf = 1; e.wb = 2'b11; e.cyc = 3 + iw; end
      7'b0010111: begin e.igt = 3'b000; e.rf = 1; e.a = 1; e.b = 1; end
      7'b1101111: begin e.igt = 3'b001; e.rf = 1; e.a = 1; e.b = 1; e.wb = 2'b10; e.pc = 2'b01; end
      7'b1100111: begin e.igt = 3'b010; e.rf = 1; e.b = 1; e.wb = 2'b10; e.pc = 2'b10; end
      7'b0000011: begin e.igt = 3'b010; e.rf = 1; e.b = 1; e.wb = 2'b01; e.mreq = 1; e.mcyc = dw + 1; e.cyc = 5 + iw + dw; end
      7'b0100011: begin e.igt = 3'b100; e.b = 1; e.mreq = 1; e.mwe = 1; e.mcyc = dw + 1; e.cyc = 4 + iw + dw; end
      7'b0010011, 7'b0011011: begin e.igt = 3'b010; e.rf = 1; e.b = 1; end
      7'b0110011, 7'b0111011: begin e.igt = 3'b111; e.rf = 1; end
      7'b1100011: begin e.igt = 3'b011; e.pc = bt ? 2'b01 : 2'b00; e.cyc = 3 + iw; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] w, input int iw, input logic bt);
    int t = 0;
    tick();
    imem_ready = 0; dmem_ready = 0;
    while (!imem_req && t < 50) begin
      tick();
      imem_ready = 0; dmem_ready = 0;
      t++;
    end
    chk("fetch_req_timeout", {63'd0, imem_req}, 64'd1);
    repeat (iw) tick();
    imem_ready = 1; imem_rdata = w; branch_taken = bt;
  endtask

  task automatic serve_dmem(input int dw);
    int t = 0;
    tick();
    imem_ready = 0; imem_rdata = $urandom();
    while (!dmem_req && t < 50) begin
      tick();
      t++;
    end
    chk("dmem_req_timeout", {63'd0, dmem_req}, 64'd1);
    repeat (dw) tick();
    dmem_ready = 1;
  endtask

  task automatic issue(input logic [31:0] w, input int iw, input int dw, input logic bt);
    exp_t e;
    e = model(w, iw, dw, bt, n_model);
    n_model++;
    q.push_back(e);
    fetch(w, iw, bt);
    if (e.mreq) serve_dmem(dw);
  endtask

  task automatic do_reset();
    reset = 1; imem_ready = 0; dmem_ready = 0;
    q.delete();
    n_model = 0;
    tick();
    tick();
    chk("rst_inst", {32'd0, inst}, 64'h13);
    chk("rst_igt", {61'd0, igt}, 64'd2);
    chk("rst_instret", instret, 64'd0);
    chk("rst_illegal", {63'd0, illegal}, 64'd0);
    chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
    chk("rst_dmem_req", {63'd0, dmem_req}, 64'd0);
    chk("rst_strobes", {60'd0, retire, pc_we, rf_we, dmem_we}, 64'd0);
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  int   cyc = 0, mc = 0;
  logic sa = 0, sb = 0, sr = 0, sm = 0, smw = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        cyc = 0; mc = 0; sa = 0; sb = 0; sr = 0; sm = 0; smw = 0;
      end else begin
        cyc++;
        sa |= alu_src_a; sb |= alu_src_b; sr |= rf_we; sm |= dmem_req; smw |= dmem_we;
        mc += int'(dmem_req);
        if (pc_we || retire) chk("pc_we_eq_retire", {63'd0, pc_we}, {63'd0, retire});
        if (retire) begin
          chk("sb_nonempty", {63'd0, q.size() != 0}, 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("inst", {32'd0, inst}, {32'd0, e.w});
            chk("igt", {61'd0, igt}, {61'd0, e.igt});
            chk("cycles", 64'(cyc), 64'(e.cyc));
            chk("rf_we", {63'd0, sr}, {63'd0, e.rf});
            chk("wb_sel", {62'd0, wb_sel}, {62'd0, e.wb});
            chk("pc_src", {62'd0, pc_src}, {62'd0, e.pc});
            chk("alu_a", {63'd0, sa}, {63'd0, e.a});
            chk("alu_b", {63'd0, sb}, {63'd0, e.b});
            chk("dmem_req", {63'd0, sm}, {63'd0, e.mreq});
            chk("dmem_we", {63'd0, smw}, {63'd0, e.mwe});
            chk("dmem_cycles", 64'(mc), 64'(e.mcyc));
            chk("instret", instret, e.cnt);
          end
          cyc = 0; mc = 0; sa = 0; sb = 0; sr = 0; sm = 0; smw = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  ops [11];
    logic [31:0] r;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0100011,
            7'b0010011, 7'b0011011, 7'b1100011, 7'b0110011, 7'b0111011};
    do_reset();
    issue(32'h0050_0093, 0, 0, 0);
    issue(32'h0020_8463, 0, 0, 1);
    issue(32'h0000_b103, 0, 3, 0);
    issue(32'h0020_b023, 0, 0, 0);
    issue(32'h1234_50b7, 0, 0, 0);
    issue(32'h0080_006f, 0, 0, 0);
    issue(32'h0000_80e7, 0, 0, 0);
    issue(32'h0020_8463, 1, 0, 0);
    for (int i = 0; i < 150; i++) begin
      r = $urandom();
      issue({r[31:7], ops[$urandom_range(0, 10)]}, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
            $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    // illegal opcode: TRAP is terminal until reset
    fetch(32'h0000_007f, 0, 0);
    tick();
    imem_ready = 0;
    tick();
    chk("trap_illegal", {63'd0, illegal}, 64'd1);
    chk("trap_sb_empty", 64'(q.size()), 64'd0);
    imem_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("trap_no_imem_req", {63'd0, imem_req}, 64'd0);
      chk("trap_hold", {63'd0, illegal}, 64'd1);
    end
    do_reset();
    issue(32'h0050_0093, 0, 0, 0);
    // reset while a load waits in MEM
    q.push_back(model(32'h0000_b103, 0, 9, 0, n_model));
    fetch(32'h0000_b103, 0, 0);
    tick();
    imem_ready = 0;
    while (!dmem_req) tick();
    tick();
    chk("mem_wait_req", {63'd0, dmem_req}, 64'd1);
    reset = 1;
    q.delete();
    n_model = 0;
    tick();
    chk("midrst_dmem_req", {63'd0, dmem_req}, 64'd0);
    chk("midrst_retire", {62'd0, retire, pc_we}, 64'd0);
    chk("midrst_instret", instret, 64'd0);
    @(posedge clk);
    #1;
    reset = 0;
    issue(32'h0050_0093, 0, 0, 0);
    issue(32'h0000_b103, 1, 1, 0);
    repeat (8) tick();
    imem_ready = 0; dmem_ready = 0;
    repeat (2) tick();
    chk("sb_drain", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
